// File: rtl/rk8e_data_break_if.sv
// Signal bundle between the RK8E data-break engine and its surroundings:
// the command source, the CPU sequencer/memory stage and the disk serializer.
interface rk8e_data_break_if;
  logic        cmd_start;
  logic        cmd_to_mem;
  logic [2:0]  cmd_field;
  logic [11:0] cmd_addr;
  logic        cmd_half;
  logic [4:0]  state;
  logic [11:0] mem_data;
  logic [11:0] dw_data;
  logic        dw_valid;
  logic        dw_ready;
  logic [11:0] dr_data;
  logic        dr_valid;
  logic        dr_ready;
  logic        break_req;
  logic [14:0] dmaAddr;
  logic [11:0] disk2mem;
  logic        to_disk;
  logic        busy;
  logic        done;

  // master: the data-break engine; slave: command source, sequencer and disk side.
  modport master (
    input  cmd_start, cmd_to_mem, cmd_field, cmd_addr, cmd_half, state, mem_data,
    input  dw_data, dw_valid, dr_ready,
    output dw_ready, dr_data, dr_valid, break_req, dmaAddr, disk2mem, to_disk, busy, done
  );

  modport slave (
    output cmd_start, cmd_to_mem, cmd_field, cmd_addr, cmd_half, state, mem_data,
    output dw_data, dw_valid, dr_ready,
    input  dw_ready, dr_data, dr_valid, break_req, dmaAddr, disk2mem, to_disk, busy, done
  );
endinterface

// File: rtl/rk8e_data_break.sv
// RK8E data-break (DMA) engine: one sector per command, FIFO-buffered, break cycles DB0..DB2.
// Optional macro DB_FIELD_CARRY_EN lets the 12-bit address wrap carry into the field.
module rk8e_data_break #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [4:0]  DB0_CODE   = 5'd0,
  parameter logic [4:0]  DB1_CODE   = 5'd0,
  parameter logic [4:0]  DB2_CODE   = 5'd0
) (
  input logic                 clk,
  input logic                 reset,
  rk8e_data_break_if.master   bus
);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] Depth = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} st_e;

  st_e              st_q, st_d;
  logic [14:0]      addr_q, addr_d, addr_inc;
  logic [8:0]       len_q, len_d, remaining_q, remaining_d, pushed_q, pushed_d;
  logic             to_disk_q, to_disk_d, in_break_q, in_break_d;
  logic [11:0]      fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]    cnt_q, cnt_d;

  logic        run, fifo_full, fifo_empty, req, db0_hit, db2_hit;
  logic        ready, rd_valid, push, pop;
  logic [11:0] head, push_data;

  always_comb begin
    run        = (st_q == StRun);
    head       = fifo_q[rptr_q];
    fifo_full  = (cnt_q == Depth);
    fifo_empty = (cnt_q == '0);
    db2_hit    = in_break_q && (bus.state == DB2_CODE);
    // While a break is in flight the request stays low, so no in-flight slot is reserved here.
    req = 1'b0;
    if (run && !in_break_q && (bus.state != DB1_CODE) && (bus.state != DB2_CODE)) begin
      req = to_disk_q ? ((remaining_q != '0) && !fifo_full) : !fifo_empty;
    end
    db0_hit   = req && (bus.state == DB0_CODE);
    // A DB2 pop frees the head slot this cycle, so a full FIFO may still accept a word.
    ready     = run && !to_disk_q && (pushed_q < len_q) && (!fifo_full || db2_hit);
    rd_valid  = to_disk_q && !fifo_empty && ((st_q == StRun) || (st_q == StDrain));
    push      = to_disk_q ? db2_hit : (bus.dw_valid && ready);
    pop       = to_disk_q ? (rd_valid && bus.dr_ready) : db2_hit;
    push_data = to_disk_q ? bus.mem_data : bus.dw_data;
  end

  always_comb begin
`ifdef DB_FIELD_CARRY_EN
    addr_inc = addr_q + 15'd1;
`else
    addr_inc = {addr_q[14:12], addr_q[11:0] + 12'd1};
`endif
  end

  always_comb begin
    st_d        = st_q;
    addr_d      = addr_q;
    len_d       = len_q;
    remaining_d = remaining_q;
    pushed_d    = pushed_q;
    to_disk_d   = to_disk_q;
    in_break_d  = in_break_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;

    if (db0_hit) in_break_d = 1'b1;
    if (db2_hit) begin
      in_break_d  = 1'b0;
      addr_d      = addr_inc;
      remaining_d = remaining_q - 9'd1;
    end
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    if (push && !to_disk_q) pushed_d = pushed_q + 9'd1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    unique case (st_q)
      StIdle: begin
        if (bus.cmd_start) begin
          addr_d      = {bus.cmd_field, bus.cmd_addr};
          len_d       = bus.cmd_half ? 9'd128 : 9'd256;
          remaining_d = bus.cmd_half ? 9'd128 : 9'd256;
          pushed_d    = '0;
          to_disk_d   = ~bus.cmd_to_mem;
          in_break_d  = 1'b0;
          wptr_d      = '0;
          rptr_d      = '0;
          cnt_d       = '0;
          st_d        = StRun;
        end
      end
      StRun:   if (remaining_q == '0) st_d = StDrain;
      StDrain: if (!to_disk_q || fifo_empty) st_d = StFin;
      StFin:   st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= StIdle;
      addr_q      <= '0;
      len_q       <= '0;
      remaining_q <= '0;
      pushed_q    <= '0;
      to_disk_q   <= 1'b0;
      in_break_q  <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      st_q        <= st_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
      pushed_q    <= pushed_d;
      to_disk_q   <= to_disk_d;
      in_break_q  <= in_break_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      if (push) fifo_q[wptr_q] <= push_data;
    end
  end

  assign bus.break_req = req;
  assign bus.dmaAddr   = addr_q;
  assign bus.disk2mem  = head;
  assign bus.dw_ready  = ready;
  assign bus.dr_valid  = rd_valid;
  assign bus.dr_data   = to_disk_q ? head : 12'd0;
  assign bus.to_disk   = to_disk_q;
  assign bus.busy      = (st_q == StRun) || (st_q == StDrain);
  assign bus.done      = (st_q == StFin);
endmodule

// File: tb/tb_rk8e_data_break.sv
// Directed bench for rk8e_data_break: sequencer, disk and memory modelled cycle by cycle.
module tb_rk8e_data_break;
  localparam logic [4:0] ST_NORM = 5'd1;
  localparam logic [4:0] ST_DB0  = 5'd8;
  localparam logic [4:0] ST_DB1  = 5'd9;
  localparam logic [4:0] ST_DB2  = 5'd10;
`ifdef DB_FIELD_CARRY_EN
  localparam logic [2:0] WRAP_F_END = 3'd6;
`else
  localparam logic [2:0] WRAP_F_END = 3'd5;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rk8e_data_break_if bus ();

  rk8e_data_break #(
    .FIFO_DEPTH (4),
    .DB0_CODE   (ST_DB0),
    .DB1_CODE   (ST_DB1),
    .DB2_CODE   (ST_DB2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          seq_ph = 0;
  int          n_breaks, n_done, n_pops, dsrc_next;
  logic        grant_en, dsrc_en, drain_en, to_mem_mode;
  logic [2:0]  exp_f;
  logic [11:0] exp_a, exp_data, exp_rd, lat_data;
  logic [14:0] lat_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive sequencer/disk/memory, sample outputs, advance the models.
  task automatic cyc();
    @(negedge clk);
    case (seq_ph)
      1:       bus.state = ST_DB0;
      2:       bus.state = ST_DB1;
      3:       bus.state = ST_DB2;
      default: bus.state = ST_NORM;
    endcase
    bus.mem_data = (seq_ph == 3) ? bus.dmaAddr[11:0] : 12'o5555;
    bus.dw_valid = dsrc_en;
    bus.dw_data  = dsrc_next[11:0];
    bus.dr_ready = drain_en;
    #1;
    if (seq_ph == 1) begin
      chk("db0_addr", 32'(bus.dmaAddr), 32'({exp_f, exp_a}));
      if (to_mem_mode) chk("db0_data", 32'(bus.disk2mem), 32'(exp_data));
      lat_addr = bus.dmaAddr;
      lat_data = bus.disk2mem;
    end
    if (seq_ph == 3) begin
      chk("db2_addr_stable", 32'(bus.dmaAddr), 32'(lat_addr));
      if (to_mem_mode) chk("db2_data_stable", 32'(bus.disk2mem), 32'(lat_data));
      n_breaks++;
      exp_data = exp_data + 12'd1;
      if (exp_a == 12'o7777) begin
        exp_a = 12'o0;
`ifdef DB_FIELD_CARRY_EN
        exp_f = exp_f + 3'd1;
`endif
      end else begin
        exp_a = exp_a + 12'd1;
      end
    end
    if (bus.dw_valid && bus.dw_ready) dsrc_next++;
    if (bus.dr_valid && bus.dr_ready) begin
      chk("dr_data", 32'(bus.dr_data), 32'(exp_rd));
      exp_rd = exp_rd + 12'd1;
      n_pops++;
    end
    if (bus.done) begin
      n_done++;
      chk("busy_with_done", 32'(bus.busy), 32'd0);
    end
    if (seq_ph == 0) seq_ph = (grant_en && bus.break_req) ? 1 : 0;
    else             seq_ph = (seq_ph == 3) ? 0 : seq_ph + 1;
  endtask

  task automatic start(input logic to_mem, input logic [2:0] f, input logic [11:0] a,
                       input logic half);
    bus.cmd_to_mem = to_mem;
    bus.cmd_field  = f;
    bus.cmd_addr   = a;
    bus.cmd_half   = half;
    to_mem_mode = to_mem;
    exp_f = f;
    exp_a = a;
    exp_data = 12'd1;
    exp_rd = a;
    n_breaks = 0;
    n_done = 0;
    n_pops = 0;
    dsrc_next = 1;
    bus.cmd_start = 1'b1;
    cyc();
    bus.cmd_start = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    int k = 0;
    int d0 = n_done;
    while (n_done == d0 && k < budget) begin
      cyc();
      k++;
    end
    chk("done_seen", 32'(n_done != d0), 32'd1);
    cyc();
    chk("done_one_pulse", 32'(bus.done), 32'd0);
    chk("busy_after_done", 32'(bus.busy), 32'd0);
    chk("done_count", 32'(n_done), 32'd1);
  endtask

  initial begin
    int k;
    bus.cmd_start = 1'b0;
    bus.cmd_to_mem = 1'b0;
    bus.cmd_field = 3'd0;
    bus.cmd_addr = 12'd0;
    bus.cmd_half = 1'b0;
    bus.state = ST_NORM;
    bus.mem_data = 12'd0;
    bus.dw_data = 12'd0;
    bus.dw_valid = 1'b0;
    bus.dr_ready = 1'b0;
    grant_en = 1'b1;
    dsrc_en = 1'b0;
    drain_en = 1'b0;
    to_mem_mode = 1'b1;
    exp_f = '0; exp_a = '0; exp_data = '0; exp_rd = '0;
    lat_addr = '0; lat_data = '0;
    n_breaks = 0; n_done = 0; n_pops = 0; dsrc_next = 1;

    // Reset values
    reset = 1'b1;
    cyc();
    cyc();
    chk("rst_break_req", 32'(bus.break_req), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_dw_ready", 32'(bus.dw_ready), 32'd0);
    chk("rst_dr_valid", 32'(bus.dr_valid), 32'd0);
    chk("rst_to_disk", 32'(bus.to_disk), 32'd0);
    chk("rst_dmaAddr", 32'(bus.dmaAddr), 32'd0);
    chk("rst_disk2mem", 32'(bus.disk2mem), 32'd0);
    chk("rst_dr_data", 32'(bus.dr_data), 32'd0);
    reset = 1'b0;
    cyc();
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Disk->memory, field 2 addr 0100, full sector
    dsrc_en = 1'b1;
    start(1'b1, 3'd2, 12'o100, 1'b0);
    chk("t1_to_disk", 32'(bus.to_disk), 32'd0);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    run_to_done(3000);
    chk("t1_breaks", 32'(n_breaks), 32'd256);
    chk("t1_words_taken", 32'(dsrc_next), 32'd257);
    chk("t1_last_addr", 32'(lat_addr), 32'({3'd2, 12'o477}));

    // Memory->disk, addr 0000, half sector, disk stalls 20 cycles
    dsrc_en = 1'b0;
    drain_en = 1'b0;
    start(1'b0, 3'd0, 12'o0, 1'b1);
    chk("t2_to_disk", 32'(bus.to_disk), 32'd1);
    repeat (19) cyc();
    chk("t2_fill_breaks", 32'(n_breaks), 32'd4);
    chk("t2_req_stopped", 32'(bus.break_req), 32'd0);
    chk("t2_dr_valid", 32'(bus.dr_valid), 32'd1);
    chk("t2_no_pops", 32'(n_pops), 32'd0);
    drain_en = 1'b1;
    run_to_done(2000);
    chk("t2_pops", 32'(n_pops), 32'd128);
    chk("t2_breaks", 32'(n_breaks), 32'd128);
    chk("t2_last_word", 32'(exp_rd), 32'(12'o200));

    // Address wrap at 7770
    drain_en = 1'b0;
    dsrc_en = 1'b1;
    start(1'b1, 3'd5, 12'o7770, 1'b0);
    run_to_done(3000);
    chk("t3_breaks", 32'(n_breaks), 32'd256);
    chk("t3_last_addr", 32'(lat_addr), 32'({WRAP_F_END, 12'o367}));

    // Push and DB2 pop together while full
    grant_en = 1'b0;
    start(1'b1, 3'd3, 12'o0, 1'b1);
    repeat (7) cyc();
    chk("t4_full_not_ready", 32'(bus.dw_ready), 32'd0);
    chk("t4_full_req", 32'(bus.break_req), 32'd1);
    chk("t4_fill_words", 32'(dsrc_next), 32'd5);
    grant_en = 1'b1;
    repeat (4) cyc();
    chk("t4_ready_in_db2", 32'(bus.dw_ready), 32'd1);
    cyc();
    chk("t4_still_full", 32'(bus.dw_ready), 32'd0);
    chk("t4_words", 32'(dsrc_next), 32'd6);
    run_to_done(2000);
    chk("t4_breaks", 32'(n_breaks), 32'd128);
    chk("t4_words_taken", 32'(dsrc_next), 32'd129);

    // Reset after 10 words, then clean restart with an ignored mid-transfer start
    start(1'b1, 3'd1, 12'o0, 1'b0);
    k = 0;
    while (n_breaks < 10 && k < 200) begin
      cyc();
      k++;
    end
    chk("t5_ten_breaks", 32'(n_breaks), 32'd10);
    reset = 1'b1;
    seq_ph = 0;
    cyc();
    reset = 1'b0;
    chk("t5_rst_req", 32'(bus.break_req), 32'd0);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    chk("t5_rst_done", 32'(bus.done), 32'd0);
    repeat (3) cyc();
    chk("t5_no_done", 32'(n_done), 32'd0);
    start(1'b1, 3'd4, 12'o200, 1'b1);
    k = 0;
    while (n_breaks < 5 && k < 200) begin
      cyc();
      k++;
    end
    bus.cmd_to_mem = 1'b0;
    bus.cmd_field = 3'd7;
    bus.cmd_addr = 12'o0;
    bus.cmd_half = 1'b0;
    bus.cmd_start = 1'b1;
    cyc();
    bus.cmd_start = 1'b0;
    chk("t5_dir_kept", 32'(bus.to_disk), 32'd0);
    run_to_done(2000);
    chk("t5_breaks", 32'(n_breaks), 32'd128);
    chk("t5_last_addr", 32'(lat_addr), 32'({3'd4, 12'o377}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
